// File: rtl/ddram_arb_if.sv
// Avalon-MM bundle used for both requester ports and the DDRAM controller port.
// "master" drives commands; "slave" drives waitrequest and read returns.
interface ddram_arb_if;
  logic [28:0] address;
  logic [7:0]  burstcount;
  logic        read;
  logic        write;
  logic [63:0] writedata;
  logic [7:0]  byteenable;
  logic        waitrequest;
  logic [63:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/ddram_arb.sv
// Two-requester round-robin arbiter onto one DDRAM Avalon-MM port. Write bursts
// lock the grant. Read tags are queued so return beats can be steered in issue order.
module ddram_arb #(
  parameter int unsigned TAGDEPTH = 4
) (
  input logic         clk_sys,
  input logic         reset_n,
  ddram_arb_if.slave  s0,
  ddram_arb_if.slave  s1,
  ddram_arb_if.master ddram
);
  localparam int unsigned PtrW = $clog2(TAGDEPTH);

  typedef enum logic [1:0] {StIdle, StCmd, StWburst} state_e;

  // Reset asserts asynchronously and is released two clk_sys edges later.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e          state_q;
  logic            gnt_q, last_gnt_q, err_q;
  logic [7:0]      wcnt_q, rcnt_q;
  logic [28:0]     address_q;
  logic [7:0]      burstcount_q, byteenable_q;
  logic [63:0]     writedata_q;
  logic [8:0]      tag_mem [TAGDEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   tag_cnt_q;

  logic [28:0] g_address;
  logic [7:0]  g_burstcount, g_byteenable, bc_eff, remaining;
  logic [63:0] g_writedata;
  logic        g_read, g_write;
  logic        s0_req, s1_req, pick, active, tag_full, tag_empty, rd_stall, gnt_wait;
  logic        rd_acc, wr_acc, beat, pop, push;
  logic [8:0]  head;

  always_comb begin
    if (gnt_q) begin
      g_address = s1.address;  g_burstcount = s1.burstcount;  g_read = s1.read;
      g_write = s1.write;  g_writedata = s1.writedata;  g_byteenable = s1.byteenable;
    end else begin
      g_address = s0.address;  g_burstcount = s0.burstcount;  g_read = s0.read;
      g_write = s0.write;  g_writedata = s0.writedata;  g_byteenable = s0.byteenable;
    end
  end

  assign s0_req    = s0.read | s0.write;
  assign s1_req    = s1.read | s1.write;
  assign pick      = (s0_req && s1_req) ? ~last_gnt_q : s1_req;
  assign active    = (state_q != StIdle);
  assign tag_full  = (tag_cnt_q == (PtrW+1)'(TAGDEPTH));
  assign tag_empty = (tag_cnt_q == '0);
  assign rd_stall  = (state_q == StCmd) && g_read && tag_full;
  assign bc_eff    = (g_burstcount == 8'd0) ? 8'd1 : g_burstcount;

  // Command outputs follow the granted requester live; in IDLE they hold the last command.
  assign ddram.address    = active ? g_address    : address_q;
  assign ddram.burstcount = active ? g_burstcount : burstcount_q;
  assign ddram.writedata  = active ? g_writedata  : writedata_q;
  assign ddram.byteenable = active ? g_byteenable : byteenable_q;
  assign ddram.read       = (state_q == StCmd) && g_read && !tag_full;
  assign ddram.write      = active && g_write && !((state_q == StCmd) && g_read);

  assign gnt_wait       = ddram.waitrequest | rd_stall;
  assign s0.waitrequest = (active && !gnt_q) ? gnt_wait : 1'b1;
  assign s1.waitrequest = (active &&  gnt_q) ? gnt_wait : 1'b1;
  assign rd_acc         = ddram.read  && !ddram.waitrequest;
  assign wr_acc         = ddram.write && !ddram.waitrequest;

  // Return path: the head tag names the owner; rcnt_q==0 means the head burst has not started.
  assign head      = tag_mem[rptr_q];
  assign beat      = ddram.readdatavalid && !tag_empty;
  assign remaining = (rcnt_q == 8'd0) ? head[7:0] : rcnt_q;
  assign pop       = beat && (remaining == 8'd1);
  assign push      = rd_acc;

  assign s0.readdatavalid = beat && !head[8];
  assign s1.readdatavalid = beat &&  head[8];
  assign s0.readdata      = rst_n ? ddram.readdata : '0;
  assign s1.readdata      = rst_n ? ddram.readdata : '0;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      gnt_q        <= 1'b0;
      last_gnt_q   <= 1'b1;
      wcnt_q       <= 8'd0;
      address_q    <= '0;
      burstcount_q <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s0_req || s1_req) begin
            gnt_q      <= pick;
            last_gnt_q <= pick;
            state_q    <= StCmd;
          end
        end
        StCmd: begin
          if (rd_acc) begin
            state_q <= StIdle;
          end else if (wr_acc) begin
            if (bc_eff > 8'd1) begin
              wcnt_q  <= bc_eff - 8'd1;
              state_q <= StWburst;
            end else begin
              state_q <= StIdle;
            end
          end else if (!g_read && !g_write) begin
            state_q <= StIdle;
          end
        end
        StWburst: begin
          if (wr_acc) begin
            wcnt_q <= wcnt_q - 8'd1;
            if (wcnt_q == 8'd1) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (active) begin
        address_q    <= g_address;
        burstcount_q <= g_burstcount;
        writedata_q  <= g_writedata;
        byteenable_q <= g_byteenable;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      tag_cnt_q <= '0;
      rcnt_q    <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      tag_cnt_q <= tag_cnt_q + 1'b1;
      else if (pop && !push) tag_cnt_q <= tag_cnt_q - 1'b1;
      if (beat) rcnt_q <= pop ? 8'd0 : remaining - 8'd1;
      if (ddram.readdatavalid && tag_empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) tag_mem[wptr_q] <= {gnt_q, bc_eff};
  end
endmodule

// File: tb/tb_ddram_arb.sv
// Directed bench for ddram_arb: bench drives both requesters and plays the DDRAM controller.
module tb_ddram_arb;
  logic clk_sys = 1'b0;
  logic reset_n;
  always #5 clk_sys = ~clk_sys;

  ddram_arb_if s0_if ();
  ddram_arb_if s1_if ();
  ddram_arb_if dd_if ();

  ddram_arb #(.TAGDEPTH(4)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .s0      (s0_if),
    .s1      (s1_if),
    .ddram   (dd_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n0 = 0;
  int n1 = 0;
  logic [64:0] rd_q[$];
  logic [28:0] acc_addr, a0, a1;
  logic [7:0]  acc_bc;
  logic        acc_rd, hit;
  int          who;

  // Every read-return beat seen by a requester, tagged with its id.
  always @(negedge clk_sys) begin
    if (s0_if.readdatavalid) begin n0++; rd_q.push_back({1'b0, s0_if.readdata}); end
    if (s1_if.readdatavalid) begin n1++; rd_q.push_back({1'b1, s1_if.readdata}); end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_req(input int id, input logic rd, input logic wr, input logic [28:0] addr,
                         input logic [7:0] bc, input logic [63:0] wd);
    if (id == 0) begin
      s0_if.read = rd; s0_if.write = wr; s0_if.address = addr;
      s0_if.burstcount = bc; s0_if.writedata = wd; s0_if.byteenable = 8'hff;
    end else begin
      s1_if.read = rd; s1_if.write = wr; s1_if.address = addr;
      s1_if.burstcount = bc; s1_if.writedata = wd; s1_if.byteenable = 8'hff;
    end
  endtask

  task automatic wait_accept(input int id, input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk_sys);
      ok = (id == 0) ? !s0_if.waitrequest : !s1_if.waitrequest;
    end
    check({tag, " accepted"}, 64'(ok), 1);
    acc_addr = dd_if.address;
    acc_bc   = dd_if.burstcount;
    acc_rd   = dd_if.read;
    tick();
  endtask

  task automatic rd(input int id, input logic [28:0] addr, input logic [7:0] bc, input string tag);
    set_req(id, 1'b1, 1'b0, addr, bc, 64'd0);
    wait_accept(id, tag);
    if (id == 0) s0_if.read = 1'b0;
    else         s1_if.read = 1'b0;
  endtask

  task automatic ret(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      dd_if.readdatavalid = 1'b1;
      dd_if.readdata      = base + 64'(i);
      tick();
    end
    dd_if.readdatavalid = 1'b0;
  endtask

  task automatic expect_beat(input int id, input logic [63:0] d, input string tag);
    logic [64:0] ent;
    check({tag, " present"}, 64'(rd_q.size() > 0), 1);
    if (rd_q.size() > 0) begin
      ent = rd_q.pop_front();
      check({tag, " id"}, 64'(ent[64]), 64'(id));
      check({tag, " data"}, ent[63:0], d);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_req(0, 1'b0, 1'b0, 29'h1234, 8'd3, 64'h55);
    set_req(1, 1'b0, 1'b0, 29'h4321, 8'd5, 64'h66);
    dd_if.waitrequest   = 1'b0;
    dd_if.readdata      = 64'hdead_beef_0000_0001;
    dd_if.readdatavalid = 1'b1;
    reset_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_sys);
    check("rst ddram_read", 64'(dd_if.read), 0);
    check("rst ddram_write", 64'(dd_if.write), 0);
    check("rst s0_waitrequest", 64'(s0_if.waitrequest), 1);
    check("rst s1_waitrequest", 64'(s1_if.waitrequest), 1);
    check("rst s0_readdatavalid", 64'(s0_if.readdatavalid), 0);
    check("rst s1_readdatavalid", 64'(s1_if.readdatavalid), 0);
    check("rst s0_readdata", s0_if.readdata, 0);
    check("rst ddram_address", 64'(dd_if.address), 0);
    dd_if.readdatavalid = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("rst err flag", 64'(dut.err_q), 0);

    // Single read, burst 4
    set_req(0, 1'b1, 1'b0, 29'h100, 8'd4, 64'd0);
    @(negedge clk_sys);
    check("t1 idle waitrequest", 64'(s0_if.waitrequest), 1);
    wait_accept(0, "t1 read");
    s0_if.read = 1'b0;
    check("t1 cmd address", 64'(acc_addr), 64'h100);
    check("t1 cmd burstcount", 64'(acc_bc), 4);
    check("t1 cmd read", 64'(acc_rd), 1);
    @(negedge clk_sys);
    check("t1 idle hold address", 64'(dd_if.address), 64'h100);
    check("t1 idle read low", 64'(dd_if.read), 0);
    tick();
    ret(4, 64'h1000);
    check("t1 s0 beats", 64'(n0), 4);
    check("t1 s1 beats", 64'(n1), 0);
    check("t1 tag fifo empty", 64'(dut.tag_cnt_q), 0);
    for (int i = 0; i < 4; i++) expect_beat(0, 64'h1000 + 64'(i), "t1 beat");

    // Contention: two rounds of four alternating read grants
    do_reset();
    a0 = 29'h200;
    a1 = 29'h300;
    for (int r = 0; r < 2; r++) begin
      set_req(0, 1'b1, 1'b0, a0, 8'd1, 64'd0);
      set_req(1, 1'b1, 1'b0, a1, 8'd1, 64'd0);
      for (int g = 0; g < 4; g++) begin
        hit = 1'b0;
        who = -1;
        for (int k = 0; k < 20 && !hit; k++) begin
          @(negedge clk_sys);
          if (!s0_if.waitrequest) begin hit = 1'b1; who = 0; end
          else if (!s1_if.waitrequest) begin hit = 1'b1; who = 1; end
        end
        check("t2 grant order", 64'(who), 64'(g % 2));
        check("t2 address", 64'(dd_if.address), 64'((who == 1) ? a1 : a0));
        tick();
        if (who == 1) begin a1 = a1 + 29'd1; s1_if.address = a1; end
        else begin a0 = a0 + 29'd1; s0_if.address = a0; end
      end
      s0_if.read = 1'b0;
      s1_if.read = 1'b0;
      ret(4, 64'h2000 + 64'(r * 16));
      for (int i = 0; i < 4; i++)
        expect_beat(i % 2, 64'h2000 + 64'(r * 16 + i), "t2 beat");
    end

    // Write burst of 8 from s1 locks out s0
    set_req(1, 1'b0, 1'b1, 29'h400, 8'd8, 64'h5000);
    wait_accept(1, "t3 first beat");
    set_req(0, 1'b1, 1'b0, 29'h500, 8'd1, 64'd0);
    s1_if.writedata = 64'h5001;
    for (int b = 2; b <= 8; b++) begin
      if (b == 4) begin
        dd_if.waitrequest = 1'b1;
        @(negedge clk_sys);
        check("t3 stall s1 waitrequest", 64'(s1_if.waitrequest), 1);
        check("t3 stall write mirrored", 64'(dd_if.write), 1);
        tick();
        dd_if.waitrequest = 1'b0;
      end
      @(negedge clk_sys);
      check("t3 s0 locked out", 64'(s0_if.waitrequest), 1);
      check("t3 s1 beat accepted", 64'(s1_if.waitrequest), 0);
      check("t3 writedata", dd_if.writedata, 64'h5000 + 64'(b - 1));
      tick();
      s1_if.writedata = 64'h5000 + 64'(b);
    end
    s1_if.write = 1'b0;
    @(negedge clk_sys);
    check("t3 idle s0 waitrequest", 64'(s0_if.waitrequest), 1);
    check("t3 idle write low", 64'(dd_if.write), 0);
    check("t3 idle hold address", 64'(dd_if.address), 64'h400);
    wait_accept(0, "t3 s0 read");
    s0_if.read = 1'b0;
    check("t3 s0 read address", 64'(acc_addr), 64'h500);
    ret(1, 64'h6000);
    expect_beat(0, 64'h6000, "t3 beat");

    // Tag FIFO full: fifth read stalls until the first burst's last beat pops
    for (int i = 0; i < 4; i++) rd(0, 29'h600 + 29'(i), 8'd2, "t4 read");
    set_req(0, 1'b1, 1'b0, 29'h700, 8'd2, 64'd0);
    repeat (4) begin
      @(negedge clk_sys);
      check("t4 full waitrequest", 64'(s0_if.waitrequest), 1);
      check("t4 full read low", 64'(dd_if.read), 0);
    end
    tick();
    dd_if.readdatavalid = 1'b1;
    dd_if.readdata      = 64'h7000;
    @(negedge clk_sys);
    check("t4 beat1 still stalled", 64'(s0_if.waitrequest), 1);
    tick();
    dd_if.readdata = 64'h7001;
    @(negedge clk_sys);
    check("t4 last beat still stalled", 64'(s0_if.waitrequest), 1);
    check("t4 last beat read low", 64'(dd_if.read), 0);
    tick();
    dd_if.readdatavalid = 1'b0;
    @(negedge clk_sys);
    check("t4 unstall waitrequest", 64'(s0_if.waitrequest), 0);
    check("t4 unstall read", 64'(dd_if.read), 1);
    check("t4 unstall address", 64'(dd_if.address), 64'h700);
    tick();
    s0_if.read = 1'b0;
    ret(8, 64'h7002);
    check("t4 tag fifo empty", 64'(dut.tag_cnt_q), 0);
    for (int i = 0; i < 10; i++) expect_beat(0, 64'h7000 + 64'(i), "t4 beat");

    // Burstcount 0 read gives one beat; a further beat is spurious
    check("t5 err clear before", 64'(dut.err_q), 0);
    rd(1, 29'h800, 8'd0, "t5 read");
    dd_if.readdatavalid = 1'b1;
    dd_if.readdata      = 64'h8000;
    @(negedge clk_sys);
    check("t5 bc0 beat steered", 64'(s1_if.readdatavalid), 1);
    tick();
    dd_if.readdata = 64'h8001;
    @(negedge clk_sys);
    check("t5 spurious s0 valid", 64'(s0_if.readdatavalid), 0);
    check("t5 spurious s1 valid", 64'(s1_if.readdatavalid), 0);
    tick();
    dd_if.readdatavalid = 1'b0;
    check("t5 tag fifo empty", 64'(dut.tag_cnt_q), 0);
    check("t5 err flag set", 64'(dut.err_q), 1);
    expect_beat(1, 64'h8000, "t5 beat");
    check("t5 no extra beats", 64'(rd_q.size()), 0);

    // Reset in the middle of an 8-beat write
    set_req(1, 1'b0, 1'b1, 29'h900, 8'd8, 64'ha000);
    wait_accept(1, "t6 first beat");
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 rst ddram_write", 64'(dd_if.write), 0);
    check("t6 rst ddram_read", 64'(dd_if.read), 0);
    check("t6 rst s0_waitrequest", 64'(s0_if.waitrequest), 1);
    check("t6 rst s1_waitrequest", 64'(s1_if.waitrequest), 1);
    check("t6 rst address", 64'(dd_if.address), 0);
    check("t6 rst writedata", dd_if.writedata, 0);
    check("t6 rst s1_readdata", s1_if.readdata, 0);
    check("t6 rst err flag", 64'(dut.err_q), 0);
    set_req(1, 1'b1, 1'b0, 29'hb00, 8'd1, 64'd0);
    set_req(0, 1'b1, 1'b0, 29'ha00, 8'd1, 64'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      check("t6 sync release hold", 64'(s0_if.waitrequest), 1);
    end
    @(negedge clk_sys);
    check("t6 first grant s0", 64'(s0_if.waitrequest), 0);
    check("t6 first grant not s1", 64'(s1_if.waitrequest), 1);
    tick();
    s0_if.read = 1'b0;
    wait_accept(1, "t6 s1 read");
    s1_if.read = 1'b0;
    ret(2, 64'hc000);
    expect_beat(0, 64'hc000, "t6 beat");
    expect_beat(1, 64'hc001, "t6 beat");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ddram_arb.md
DDRAM_ARB -- requirements
Module: ddram_arb

Interface
Parameters:
REQ-001 SHALL provide parameter TAGDEPTH, default 4, meaning the maximum number of read bursts outstanding on the DDRAM port; legal values are 2 to 16, powers of two.

Ports:
REQ-002 SHALL provide clk_sys  in  1  system clock; every flop is clocked on its rising edge.
REQ-003 SHALL provide reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL provide, for each requester N in {0,1}, an Avalon-MM slave port with these signals:
- sN_address  in  29
- sN_burstcount  in  8
- sN_read  in  1
- sN_write  in  1
- sN_writedata  in  64
- sN_byteenable  in  8
- sN_waitrequest  out  1
- sN_readdata  out  64
- sN_readdatavalid  out  1
REQ-005 SHALL provide the master side toward the DDRAM controller with these signals:
- ddram_address  out  29
- ddram_burstcount  out  8
- ddram_read  out  1
- ddram_write  out  1
- ddram_writedata  out  64
- ddram_byteenable  out  8
- ddram_waitrequest  in  1
- ddram_readdata  in  64
- ddram_readdatavalid  in  1

Function
REQ-006 SHALL use an arbiter FSM with three states:
- IDLE
- CMD: a requester is granted, and its first command word is pending.
- WBURST: remaining beats of a write burst are pending; the grant is locked.
REQ-007 IDLE SHALL grant, in the cycle after a request appears, whichever requester asserts read or write; if both request, it grants the one that was not granted last (round-robin). After reset, requester 0 has priority.
REQ-008 In CMD and WBURST, the DDRAM command outputs SHALL mirror the granted requester's inputs combinationally; the non-granted requester SHALL see sN_waitrequest=1.
REQ-009 The granted requester's sN_waitrequest SHALL equal ddram_waitrequest, or 1 when a read is pending and the tag FIFO is full; in that case ddram_read is held at 0.
REQ-010 A read is accepted when ddram_read=1 and ddram_waitrequest=0. On acceptance:
- The block pushes the tag {requester id, burstcount} into the tag FIFO.
- The FSM returns to IDLE the next cycle.
REQ-011 A write beat is accepted when ddram_write=1 and ddram_waitrequest=0. If burstcount>1 at the first beat, the block loads a beat counter with burstcount-1 and moves to WBURST. WBURST returns to IDLE when the counter reaches 0 on an accepted beat.
REQ-012 A burstcount of 0 SHALL be treated as 1, for both the tag and the beat counter.
REQ-013 Each ddram_readdatavalid beat SHALL be steered to the requester in the head tag: same-cycle combinational sN_readdatavalid, with ddram_readdata broadcast to both sN_readdata. A remaining-beats counter loaded from the head tag counts the beats; the tag is popped on the last beat.
REQ-014 A tag push and a tag pop in the same cycle SHALL both take effect, and the occupancy count stays unchanged.
REQ-015 A readdatavalid beat arriving with the tag FIFO empty SHALL be dropped: no sN_readdatavalid is asserted, and a sticky internal error flag is set for the bench to observe.
REQ-016 In IDLE, the block SHALL drive ddram_read=0 and ddram_write=0; ddram_address, burstcount, writedata and byteenable hold their last values.
REQ-017 Arbitration SHALL be non-preemptive: a write burst completes before any other grant. Reads from both requesters may interleave, and return data is delivered in issue order.

Reset
REQ-018 Asserting reset_n=0 SHALL asynchronously force:
- FSM to IDLE
- priority to requester 0
- tag FIFO empty
- both counters to 0
- error flag to 0
REQ-019 While reset_n=0, the outputs SHALL be:
- ddram_read=0, ddram_write=0
- s0_waitrequest=1, s1_waitrequest=1
- s0_readdatavalid=0, s1_readdatavalid=0
- all other outputs 0
REQ-020 If reset is asserted mid-burst, the block SHALL abandon all transactions without completing them. Deassertion SHALL be synchronized to clk_sys, so the FSM leaves IDLE no earlier than the second rising edge after reset_n rises.

Verification
REQ-021 Single read: s0 reads address 0x100 with burstcount 4; the DDRAM model returns 4 beats. Required: 4 s0_readdatavalid pulses, 0 on s1, tag FIFO empty afterwards.
REQ-022 Contention: s0 and s1 both assert read every cycle for 8 grants. Required: grants alternate 0,1,0,1…; read data returns in issue order, each beat steered to the correct requester.
REQ-023 Write burst lock: s1 writes burstcount 8 while s0 requests a read from beat 2 onward. Required: s0_waitrequest=1 until the 8th s1 beat is accepted; the s0 read is granted afterwards.
REQ-024 Backpressure and full: TAGDEPTH=4, five reads issued with data withheld. Required: the fifth read sees waitrequest=1 until the first return burst's last beat pops its tag; ddram_read=0 throughout the stall.
REQ-025 Reset mid-write: reset_n is pulled low after 3 of 8 beats. Required: outputs immediately match REQ-019; the first grant after release goes to requester 0.
REQ-026 Edge cases:
- Burstcount 0 on a read: exactly 1 beat is steered.
- A spurious readdatavalid with no outstanding read: dropped, and the error flag is set.
